pmod_arbiter: RTL and testbench

PMOD_ARBITER -- requirements
Module: pmod_arbiter

---
 rtl/pmod_arbiter_pkg.sv | 15 +
 rtl/pmod_sync.sv | 30 +++
 rtl/pmod_arbiter.sv | 134 +++++++++++++
 tb/tb_pmod_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_arbiter_pkg.sv
// Shared types and helpers for the PMOD ownership arbiter.
// The owner code NUM_SS always denotes the core.
package pmod_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_DRAIN  = 1'b1
    } arb_state_e;

    // Any request outside 0..num_ss-1 is a request for the core.
    function automatic logic [7:0] norm_sel(input logic [7:0] sel, input logic [7:0] num_ss);
        return (sel < num_ss) ? sel : num_ss;
    endfunction

endpackage

// File: rtl/pmod_sync.sv
// Multi-stage synchroniser for the asynchronous PMOD pad inputs.
// Stage 0 samples the pad; the last stage is the only safe output.
module pmod_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/pmod_arbiter.sv
// Hands the PMOD GPIO pins between the core and a set of subsystems,
// tristating the pins for a guard period on every change of owner.
module pmod_arbiter
    import pmod_arbiter_pkg::*;
#(
    parameter int IOCELL_CFG_W = 5,
    parameter int IOCELL_COUNT = 26,
    parameter int NUM_GPIO     = 8,
    parameter int NUM_SS       = 5,
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic [IOCELL_COUNT*IOCELL_CFG_W-1:0] cell_cfg_from_core,
    output logic [IOCELL_COUNT*IOCELL_CFG_W-1:0] cell_cfg_to_io,
    input  logic [NUM_GPIO-1:0]                 gpio_from_core,
    output logic [NUM_GPIO-1:0]                 gpio_to_core,
    input  logic [NUM_GPIO-1:0]                 gpio_from_io,
    output logic [NUM_GPIO-1:0]                 gpio_to_io,
    input  logic [7:0]                          pmod_sel,
    input  logic [NUM_SS*NUM_GPIO-1:0]          ss_pmod_gpio_oe,
    input  logic [NUM_SS*NUM_GPIO-1:0]          ss_pmod_gpo,
    output logic [NUM_SS*NUM_GPIO-1:0]          ss_pmod_gpi,
    output logic [NUM_SS-1:0]                   ss_grant,
    output logic                                switch_busy,
    output logic [7:0]                          active_sel
);

    localparam int         PMOD_BASE  = IOCELL_COUNT - NUM_GPIO;
    localparam logic [7:0] OWNER_CORE = 8'(NUM_SS);
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [7:0]          owner_q, owner_d;
    logic [7:0]          pending_q, pending_d;
    logic [7:0]          count_q, count_d;
    logic [7:0]          sel_n;
    logic [NUM_GPIO-1:0] gpio_sync;

    pmod_sync #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d_in     (gpio_from_io),
        .q_out    (gpio_sync)
    );

    assign gpio_to_core = gpio_sync;
    assign sel_n        = norm_sel(pmod_sel, OWNER_CORE);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_ACTIVE;
            owner_q   <= OWNER_CORE;
            pending_q <= OWNER_CORE;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // A new request during DRAIN restarts the guard; the owner only changes once
    // the request has been stable for the whole guard period.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        pending_d = pending_q;
        count_d   = count_q;
        case (state_q)
            ST_ACTIVE: begin
                if (sel_n != owner_q) begin
                    state_d   = ST_DRAIN;
                    pending_d = sel_n;
                    count_d   = GUARD_LOAD;
                end
            end
            ST_DRAIN: begin
                if (sel_n != pending_q) begin
                    pending_d = sel_n;
                    count_d   = GUARD_LOAD;
                end else if (count_q == 8'd0) begin
                    owner_d = pending_q;
                    state_d = ST_ACTIVE;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_comb begin
        cell_cfg_to_io = cell_cfg_from_core;
        gpio_to_io     = '0;
        ss_pmod_gpi    = '0;
        ss_grant       = '0;
        for (int j = 0; j < NUM_GPIO; j++) begin
            cell_cfg_to_io[(PMOD_BASE + j) * IOCELL_CFG_W] = 1'b0;
        end
        if (state_q == ST_ACTIVE) begin
            if (owner_q == OWNER_CORE) begin
                gpio_to_io = gpio_from_core;
                for (int j = 0; j < NUM_GPIO; j++) begin
                    cell_cfg_to_io[(PMOD_BASE + j) * IOCELL_CFG_W] =
                        cell_cfg_from_core[(PMOD_BASE + j) * IOCELL_CFG_W];
                end
            end else begin
                for (int k = 0; k < NUM_SS; k++) begin
                    if (owner_q == 8'(k)) begin
                        gpio_to_io = ss_pmod_gpo[k*NUM_GPIO +: NUM_GPIO];
                        ss_pmod_gpi[k*NUM_GPIO +: NUM_GPIO] = gpio_sync;
                        ss_grant[k] = 1'b1;
                        for (int j = 0; j < NUM_GPIO; j++) begin
                            cell_cfg_to_io[(PMOD_BASE + j) * IOCELL_CFG_W] =
                                ss_pmod_gpio_oe[k*NUM_GPIO + j];
                        end
                    end
                end
            end
        end
    end

    assign switch_busy = (state_q == ST_DRAIN);
    assign active_sel  = owner_q;

endmodule

// File: tb/tb_pmod_arbiter.sv
// Randomised bench for pmod_arbiter: a deadline-based ownership model and a
// pad-history queue predict every output, checked each cycle at the falling edge.
module tb_pmod_arbiter;

    localparam int CFG_W    = 5;
    localparam int CELLS    = 26;
    localparam int NG       = 8;
    localparam int NSS      = 5;
    localparam int GUARD    = 4;
    localparam int SYNC     = 2;
    localparam int CFG_BITS = CELLS * CFG_W;
    localparam int PBASE    = CELLS - NG;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CFG_BITS-1:0] cfg_in;
    logic [CFG_BITS-1:0] cfg_out;
    logic [NG-1:0]       core_gpo;
    logic [NG-1:0]       core_gpi;
    logic [NG-1:0]       pad_in;
    logic [NG-1:0]       pad_out;
    logic [7:0]          sel;
    logic [7:0]          active_sel;
    logic [NSS*NG-1:0]   ss_oe;
    logic [NSS*NG-1:0]   ss_gpo;
    logic [NSS*NG-1:0]   ss_gpi;
    logic [NSS-1:0]      grant;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int            m_owner;
    int            m_pend;
    int            m_deadline;
    int            m_cyc;
    bit            m_busy;
    logic [NG-1:0] exp_q[$];

    pmod_arbiter #(
        .IOCELL_CFG_W (CFG_W),
        .IOCELL_COUNT (CELLS),
        .NUM_GPIO     (NG),
        .NUM_SS       (NSS),
        .GUARD_CYCLES (GUARD),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk_in             (clk),
        .reset_in           (rst),
        .cell_cfg_from_core (cfg_in),
        .cell_cfg_to_io     (cfg_out),
        .gpio_from_core     (core_gpo),
        .gpio_to_core       (core_gpi),
        .gpio_from_io       (pad_in),
        .gpio_to_io         (pad_out),
        .pmod_sel           (sel),
        .ss_pmod_gpio_oe    (ss_oe),
        .ss_pmod_gpo        (ss_gpo),
        .ss_pmod_gpi        (ss_gpi),
        .ss_grant           (grant),
        .switch_busy        (busy),
        .active_sel         (active_sel)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int norm(input logic [7:0] s);
        return (int'(s) < NSS) ? int'(s) : NSS;
    endfunction

    function automatic logic [NG-1:0] pmod_oe(input logic [CFG_BITS-1:0] c);
        logic [NG-1:0] r;
        for (int j = 0; j < NG; j++) r[j] = c[(PBASE + j) * CFG_W];
        return r;
    endfunction

    function automatic logic [CFG_BITS-1:0] rand_cfg();
        logic [159:0] v;
        for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom();
        return v[CFG_BITS-1:0];
    endfunction

    // Ownership model: a stable request becomes the owner GUARD edges after it was first seen.
    always @(posedge clk or posedge rst) begin
        int s;
        if (rst) begin
            m_owner = NSS;
            m_pend  = NSS;
            m_busy  = 1'b0;
            m_cyc   = 0;
            exp_q.delete();
        end else begin
            s = norm(sel);
            m_cyc++;
            if (!m_busy) begin
                if (s != m_owner) begin
                    m_busy     = 1'b1;
                    m_pend     = s;
                    m_deadline = m_cyc + GUARD;
                end
            end else if (s != m_pend) begin
                m_pend     = s;
                m_deadline = m_cyc + GUARD;
            end else if (m_cyc == m_deadline) begin
                m_owner = m_pend;
                m_busy  = 1'b0;
            end
            exp_q.push_back(pad_in);
            if (exp_q.size() > SYNC) void'(exp_q.pop_front());
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin : compare
        logic [CFG_BITS-1:0] e_cfg;
        logic [NG-1:0]       e_io;
        logic [NG-1:0]       e_sync;
        logic [NSS*NG-1:0]   e_gpi;
        logic [NSS-1:0]      e_grant;
        e_sync  = (exp_q.size() >= SYNC) ? exp_q[exp_q.size() - SYNC] : '0;
        e_cfg   = cfg_in;
        e_io    = '0;
        e_gpi   = '0;
        e_grant = '0;
        for (int j = 0; j < NG; j++) e_cfg[(PBASE + j) * CFG_W] = 1'b0;
        if (!m_busy) begin
            if (m_owner == NSS) begin
                e_io = core_gpo;
                for (int j = 0; j < NG; j++) e_cfg[(PBASE + j) * CFG_W] = cfg_in[(PBASE + j) * CFG_W];
            end else begin
                e_io = ss_gpo[m_owner*NG +: NG];
                for (int j = 0; j < NG; j++) e_cfg[(PBASE + j) * CFG_W] = ss_oe[m_owner*NG + j];
                e_gpi[m_owner*NG +: NG] = e_sync;
                e_grant[m_owner] = 1'b1;
            end
        end
        chk("cell_cfg_to_io", cfg_out, e_cfg);
        chk("gpio_to_io", pad_out, e_io);
        chk("gpio_to_core", core_gpi, e_sync);
        chk("ss_pmod_gpi", ss_gpi, e_gpi);
        chk("ss_grant", grant, e_grant);
        chk("switch_busy", busy, m_busy);
        chk("active_sel", active_sel, m_owner);
    end

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        sel      = 8'hFF;
        cfg_in   = rand_cfg();
        core_gpo = 8'h5A;
        pad_in   = '0;
        ss_oe    = '0;
        ss_gpo   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, core owns the PMOD
        @(negedge clk);
        chk("rst_active_sel", active_sel, 8'd5);
        chk("rst_grant", grant, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_gpo", pad_out, 8'h5A);
        drive_slot();
        core_gpo = 8'hC3;
        @(negedge clk);
        chk("core_gpo_track", pad_out, 8'hC3);

        // Handover core -> ss2: four guard cycles then the new owner
        drive_slot();
        ss_gpo[2*NG +: NG] = 8'h3C;
        ss_oe[2*NG +: NG]  = 8'hF0;
        sel = 8'd2;
        repeat (4) begin
            next_cycle();
            chk("guard_busy", busy, 1'b1);
            chk("guard_oe_off", pmod_oe(cfg_out), 8'h00);
        end
        next_cycle();
        chk("ss2_grant", grant, 5'b00100);
        chk("ss2_gpo", pad_out, 8'h3C);
        chk("ss2_oe", pmod_oe(cfg_out), 8'hF0);

        // 2 -> 3, redirected to 1 after two DRAIN cycles: guard restarts, ss3 never granted
        drive_slot();
        sel = 8'd3;
        repeat (2) begin
            next_cycle();
            chk("redir_busy", busy, 1'b1);
            chk("ss3_never", grant[3], 1'b0);
        end
        #1 sel = 8'd1;
        repeat (4) begin
            next_cycle();
            chk("restart_busy", busy, 1'b1);
            chk("ss3_never", grant[3], 1'b0);
        end
        next_cycle();
        chk("redir_owner", active_sel, 8'd1);
        chk("redir_grant", grant, 5'b00010);

        // Pad 0xA5 reaches the owner exactly SYNC_STAGES cycles later
        drive_slot();
        pad_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 pad_in = 8'hA5;
        next_cycle();
        chk("sync_not_early", core_gpi, 8'h00);
        next_cycle();
        chk("sync_core", core_gpi, 8'hA5);
        chk("sync_owner_gpi", ss_gpi, 40'h00_0000_A500);

        // Reset during DRAIN returns the PMOD to the core at once
        drive_slot();
        sel = 8'd4;
        next_cycle();
        chk("pre_rst_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst_drain_owner", active_sel, 8'd5);
        chk("rst_drain_busy", busy, 1'b0);
        sel = 8'hFF;
        drive_slot();
        rst = 1'b0;

        // Out-of-range select while the core owns: no handover
        drive_slot();
        sel = 8'd7;
        repeat (6) begin
            next_cycle();
            chk("sel7_no_drain", busy, 1'b0);
            chk("sel7_core", active_sel, 8'd5);
        end

        // Randomised traffic
        for (int it = 0; it < 3000; it++) begin
            int r;
            drive_slot();
            pad_in   = NG'($urandom());
            core_gpo = NG'($urandom());
            ss_oe    = {$urandom(), $urandom()};
            ss_gpo   = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) cfg_in = rand_cfg();
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 9);
                if (r <= 7)      sel = 8'(r);
                else if (r == 8) sel = 8'hFF;
                else             sel = 8'($urandom());
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        drive_slot();
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
